axis_fifo_frame: RTL and testbench



---
 rtl/axis_fifo_pkg.sv | 10 +
 rtl/axis_fifo_ram.sv | 27 ++
 rtl/axis_fifo_frame.sv | 103 ++++++++++
 tb/tb_axis_fifo_frame.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: pointer width, depth and tuser bad-bit helpers shared by the frame FIFO
package axis_fifo_pkg;
  localparam int BAD_BIT = 0;
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port RAM, sync write, registered read with enable (doubles as output register)
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int AW = 2,
  parameter int W  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [depth(AW)];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axis_fifo_frame.sv
// axis_fifo_frame: same-clock AXI-Stream FIFO with optional store-and-forward frame dropping.
// Define AXIS_FIFO_STATUS_EN to add status_level/status_overflow/status_bad_frame outputs.
module axis_fifo_frame
  import axis_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int FRAME_FIFO = 0
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic [USER_WIDTH-1:0] input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic [USER_WIDTH-1:0] output_axis_tuser
`ifdef AXIS_FIFO_STATUS_EN
  , output logic [ADDR_WIDTH:0] status_level
  , output logic                status_overflow
  , output logic                status_bad_frame
`endif
);
  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(depth(ADDR_WIDTH));
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_cur_q, wr_cur_d, rd_ptr_q, rd_ptr_d;
  logic drop_q, drop_d, tvalid_q, tvalid_d;
  logic full, empty, in_acc, write, eof, read;
  assign full  = (wr_cur_q - rd_ptr_q) == DEPTH;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign input_axis_tready = async_rst_n & (~full | drop_q);
  assign in_acc = input_axis_tvalid & input_axis_tready;
  assign write  = in_acc & ~drop_q;
  assign eof    = in_acc & input_axis_tlast;
  assign read   = (output_axis_tready | ~tvalid_q) & ~empty;
  always_comb begin
    wr_cur_d = write ? wr_cur_q + 1'b1 : wr_cur_q;
    wr_ptr_d = wr_ptr_q;
    drop_d   = drop_q;
    rd_ptr_d = read ? rd_ptr_q + 1'b1 : rd_ptr_q;
    tvalid_d = (output_axis_tready | ~tvalid_q) ? ~empty : tvalid_q;
    if (FRAME_FIFO == 0) wr_ptr_d = wr_cur_d;
    else if (eof) begin
      if (drop_q | input_axis_tuser[BAD_BIT]) begin
        wr_cur_d = wr_ptr_q;
        drop_d   = 1'b0;
      end else wr_ptr_d = wr_cur_d;
    end else if (full & ~drop_q & ((wr_cur_q - wr_ptr_q) == DEPTH)) begin
      // the in-progress frame alone fills the RAM: it can never commit, so discard the rest
      drop_d   = 1'b1;
      wr_cur_d = wr_ptr_q;
    end
  end
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr_q <= '0;
      wr_cur_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_cur_q <= wr_cur_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
      tvalid_q <= tvalid_d;
    end
  end
  assign output_axis_tvalid = tvalid_q;
  axis_fifo_ram #(.AW(ADDR_WIDTH), .W(DATA_WIDTH + USER_WIDTH + 1)) u_ram (
    .clk     (clk),
    .rst_n   (async_rst_n),
    .we_i    (write),
    .waddr_i (wr_cur_q[ADDR_WIDTH-1:0]),
    .wdata_i ({input_axis_tlast, input_axis_tuser, input_axis_tdata}),
    .re_i    (read),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o ({output_axis_tlast, output_axis_tuser, output_axis_tdata})
  );
`ifdef AXIS_FIFO_STATUS_EN
  logic [PW-1:0] level_q;
  logic ovf_q, bad_q;
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      level_q <= wr_ptr_d - rd_ptr_d;
      ovf_q   <= eof & drop_q;
      bad_q   <= (FRAME_FIFO != 0) & eof & ~drop_q & input_axis_tuser[BAD_BIT];
    end
  end
  assign status_level     = level_q;
  assign status_overflow  = ovf_q;
  assign status_bad_frame = bad_q;
`endif
endmodule

// File: tb/tb_axis_fifo_frame.sv
// tb_axis_fifo_frame: directed + random checks of both FIFO modes against a queue-based frame model
module tb_axis_fifo_frame;
  localparam int AW = 2, DW = 8, UW = 1, DEPTH = 4;
  typedef struct packed {logic l; logic [UW-1:0] u; logic [DW-1:0] d;} beat_t;
  logic clk = 0, rst_n = 0;
  logic [DW-1:0] id [2], od [2];
  logic [UW-1:0] iu [2], ou [2];
  logic iv [2], ir [2], il [2], ov [2], ordy [2], ol [2];
`ifdef AXIS_FIFO_STATUS_EN
  logic [AW:0] lvl [2];
  logic ovf [2], bad [2];
`endif
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_fifo_frame #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .FRAME_FIFO(g)) u_dut (
      .clk                (clk),
      .async_rst_n        (rst_n),
      .input_axis_tdata   (id[g]),
      .input_axis_tvalid  (iv[g]),
      .input_axis_tready  (ir[g]),
      .input_axis_tlast   (il[g]),
      .input_axis_tuser   (iu[g]),
      .output_axis_tdata  (od[g]),
      .output_axis_tvalid (ov[g]),
      .output_axis_tready (ordy[g]),
      .output_axis_tlast  (ol[g]),
      .output_axis_tuser  (ou[g])
`ifdef AXIS_FIFO_STATUS_EN
      , .status_level     (lvl[g])
      , .status_overflow  (ovf[g])
      , .status_bad_frame (bad[g])
`endif
    );
  end
  int nassert = 0, nfail = 0, cur = 0;
  beat_t exp_q[$], fr_q[$], held;
  logic hold = 0, pend_ovf = 0, pend_bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nassert++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  function automatic beat_t bt(input logic [DW-1:0] d, input logic l, input logic u);
    return {l, u, d};
  endfunction
  // reference: plain FIFO passes every beat; frame FIFO keeps whole frames of <= DEPTH beats without the bad flag
  task automatic model_in(input beat_t b);
    if (cur == 0) begin
      exp_q.push_back(b);
      return;
    end
    fr_q.push_back(b);
    if (b.l) begin
      if (fr_q.size() > DEPTH) pend_ovf = 1;
      else if (b.u[0]) pend_bad = 1;
      else foreach (fr_q[i]) exp_q.push_back(fr_q[i]);
      fr_q.delete();
    end
  endtask
  task automatic step(input logic v, input beat_t b, input logic r, output logic acc);
    beat_t e;
    iv[cur] = v;
    {il[cur], iu[cur], id[cur]} = b;
    ordy[cur] = r;
    #1;
`ifdef AXIS_FIFO_STATUS_EN
    chk("ovf_pulse", ovf[cur], pend_ovf);
    chk("bad_pulse", bad[cur], pend_bad);
    chk("level", lvl[cur], exp_q.size() - ov[cur]);
`endif
    pend_ovf = 0;
    pend_bad = 0;
    if (hold) chk("stable", {ov[cur], ol[cur], ou[cur], od[cur]}, {1'b1, held});
    acc = v & ir[cur];
    if (acc) model_in(b);
    if (ov[cur] & r) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      chk("out_beat", {ol[cur], ou[cur], od[cur]}, e);
    end
    hold = ov[cur] & ~r;
    held = {ol[cur], ou[cur], od[cur]};
    @(negedge clk);
  endtask
  task automatic send(input beat_t b, input logic r, input logic rnd);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, b, rnd ? 1'($urandom_range(0, 1)) : r, acc);
      n++;
    end while (!acc && n < 30);
    chk("send_accept", acc, 1);
  endtask
  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ov[cur]) && n < 40) begin
      step(1'b0, '0, 1'b1, acc);
      n++;
    end
    repeat (3) step(1'b0, '0, 1'b1, acc);
    chk("drained", exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; il[k] = 0; iu[k] = 0; id[k] = 0; ordy[k] = 0;
    end
    exp_q.delete();
    fr_q.delete();
    hold = 0; pend_ovf = 0; pend_bad = 0;
    #1;
    chk("rst_tvalid", ov[cur], 0);
    chk("rst_out", {ol[cur], ou[cur], od[cur]}, 0);
    chk("rst_tready", ir[cur], 0);
`ifdef AXIS_FIFO_STATUS_EN
    chk("rst_level", lvl[cur], 0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic acc, v;
    int sent, t, len;
    beat_t nb;
    @(negedge clk);
    // 1: plain FIFO, consumer stalled: output register plus DEPTH entries fill before tready drops
    cur = 0;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(bt(8'(k * 17), 1'b0, 1'b0), 1'b0, 1'b0);
      if (k == 4) chk("t1_ready_after4", ir[0], 1);
    end
    chk("t1_full", ir[0], 0);
    drain();
    // 2: frame mode holds a frame back until its last beat commits
    cur = 1;
    do_reset();
    send(bt(8'hA1, 1'b0, 1'b0), 1'b1, 1'b0);
    chk("t2_hold1", ov[1], 0);
    send(bt(8'hA2, 1'b0, 1'b0), 1'b1, 1'b0);
    chk("t2_hold2", ov[1], 0);
    send(bt(8'hA3, 1'b1, 1'b0), 1'b1, 1'b0);
    chk("t2_hold3", ov[1], 0);
    step(1'b0, '0, 1'b1, acc);
    chk("t2_valid", ov[1], 1);
    chk("t2_first", od[1], 8'hA1);
    drain();
    // 3: bad frame discarded, following good frame passes
    send(bt(8'hD1, 1'b0, 1'b0), 1'b1, 1'b0);
    send(bt(8'hD2, 1'b1, 1'b1), 1'b1, 1'b0);
    send(bt(8'hB1, 1'b1, 1'b0), 1'b1, 1'b0);
    drain();
    // 4: over-length frame fully accepted and dropped, then a short frame passes
    for (int k = 0; k < 6; k++) send(bt(8'(8'hE0 + k), k == 5, 1'b0), 1'b1, 1'b0);
    chk("t4_none", ov[1], 0);
    send(bt(8'hC1, 1'b1, 1'b0), 1'b1, 1'b0);
    drain();
    // 5: plain FIFO random stream with consumer ready toggling 1010..
    cur = 0;
    sent = 0;
    t = 0;
    nb = beat_t'($urandom);
    while ((sent < 20 || exp_q.size() != 0 || ov[0]) && t < 300) begin
      v = (sent < 20) && ($urandom_range(0, 3) != 0);
      step(v, nb, ~t[0], acc);
      if (acc) begin
        sent++;
        nb = beat_t'($urandom);
      end
      t++;
    end
    chk("t5_sent", sent, 20);
    chk("t5_empty", exp_q.size(), 0);
    // 5b: frame mode random frames, lengths 1..6, some bad, random consumer
    cur = 1;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send(bt(8'($urandom), k == len - 1, (k == len - 1) && ($urandom_range(0, 3) == 0)), 1'b0, 1'b1);
    end
    drain();
    // 6: async reset mid-frame with committed data waiting
    do_reset();
    send(bt(8'h51, 1'b1, 1'b0), 1'b0, 1'b0);
    send(bt(8'h52, 1'b1, 1'b0), 1'b0, 1'b0);
    send(bt(8'h53, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("t6_pre_valid", ov[1], 1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_tvalid", ov[1], 0);
    chk("t6_async_tready", ir[1], 0);
    chk("t6_async_out", {ol[1], ou[1], od[1]}, 0);
`ifdef AXIS_FIFO_STATUS_EN
    chk("t6_async_level", lvl[1], 0);
`endif
    do_reset();
    send(bt(8'h61, 1'b0, 1'b0), 1'b1, 1'b0);
    send(bt(8'h62, 1'b1, 1'b0), 1'b1, 1'b0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
